gbsha_decim: RTL
================

GBSHA_DECIM -- requirements
Module: gbsha_decim

Integrate-and-dump decimator sitting directly downstream of the FIR stage. It consumes the FIR's per-cycle signed output and emits one block-sum/average per DECIM input samples on a valid/ready port.

Interface
REQ-001 The block SHALL have parameter BW_in, default 8: width of the signed two's-complement input sample.
REQ-002 The block SHALL have parameter BW_out, default 8: width of the signed two's-complement output word.
REQ-003 The block SHALL have parameter DECIM_LOG2, default 2: decimation factor D = 2^DECIM_LOG2, legal range 1..4.
REQ-004 The block SHALL have parameter SHIFT, default 2: right-shift applied to the block sum, legal range 0..DECIM_LOG2.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port y_in, input, BW_in bits: signed sample from the FIR stage.
REQ-008 The block SHALL have port in_valid, input, 1 bit: y_in is valid this cycle.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block accepts y_in this cycle.
REQ-010 The block SHALL have port y_out, output, BW_out bits: signed decimated result.
REQ-011 The block SHALL have port out_valid, output, 1 bit: y_out holds an unconsumed result.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer takes y_out this cycle.
REQ-013 The block SHALL have port sat, output, 1 bit: sticky flag, set when any output was saturated.

Function
REQ-014 Acceptance SHALL occur exactly when in_valid && in_ready on a rising clk edge.
REQ-015 The accumulator SHALL be signed, BW_in+DECIM_LOG2 bits wide, with y_in sign-extended, so that no internal overflow occurs.
REQ-016 The sample counter SHALL be DECIM_LOG2 bits wide; each acceptance increments it, and it wraps from D-1 to 0.
REQ-017 An accepted sample with count < D-1 SHALL update the accumulator as acc <= acc + y_in.
REQ-018 An accepted sample with count = D-1 (dump) SHALL perform all of the following in the same edge:
- compute sum = acc + y_in;
- load y_out with sat(sum >>> SHIFT), where >>> is an arithmetic shift (floor);
- set out_valid to 1;
- clear acc to 0.
REQ-019 sat() SHALL clamp the result to the range [-2^(BW_out-1), 2^(BW_out-1)-1], and SHALL set sat to 1 whenever clamping occurs.
REQ-020 Latency SHALL be one cycle: out_valid rises on the edge that accepts the D-th sample.
REQ-021 y_out and out_valid SHALL hold steady while out_valid && !out_ready.
REQ-022 out_valid SHALL clear on out_ready && out_valid, unless a dump occurs on the same edge.
REQ-023 A dump coinciding with out_ready && out_valid SHALL load the new result, and out_valid SHALL stay 1, with no bubble.
REQ-024 in_ready SHALL equal !(count == D-1 && out_valid && !out_ready), a combinational function of state and out_ready: only the dump sample is back-pressured.
REQ-025 in_valid=0 SHALL leave acc and count unchanged.
REQ-026 Samples with count < D-1 SHALL be accepted regardless of output state.
REQ-027 sat SHALL clear only on reset.

Reset
REQ-028 When reset_n=0 at a rising edge, the block SHALL clear acc, count, y_out, out_valid and sat to 0, with reset taking priority over all other events.
REQ-029 During and after reset, in_ready SHALL be 1.
REQ-030 A reset mid-block SHALL discard all partial samples, so that the next accepted sample is sample 0 of a new block.
REQ-031 An unconsumed output SHALL be discarded by reset.

Verification
REQ-032 Reset scenario: hold reset_n=0 for 2 cycles -> y_out=0, out_valid=0, sat=0, in_ready=1.
REQ-033 Average scenario (defaults): feed 10,20,30,40 on consecutive cycles with out_ready=1 -> y_out=25 and out_valid=1 for exactly one cycle, one cycle after the sample 40 edge.
REQ-034 Floor-rounding scenario: feed -1,-2,-3,-3 -> sum=-9, y_out=-3 (floor, not -2), sat=0.
REQ-035 Backpressure scenario: hold out_ready=0 and stream 1..8 continuously -> y_out=2 held stable; in_ready=0 when 8 is presented; 8 is accepted only once out_ready=1, y_out=2 is consumed on that same edge and y_out=6 appears with no bubble.
REQ-036 Saturation scenario (SHIFT=0): feed 100,100,100,100 -> y_out=127, sat=1; then feed -1 x4 -> y_out=-4 with sat still 1.
REQ-037 Mid-block reset scenario: feed 50,50, pulse reset_n=0 for 1 cycle, then feed 4,4,4,4 -> y_out=4.

Source files
------------

// File: rtl/gbsha_decim.sv
// Integrate-and-dump decimator: sums 2^DECIM_LOG2 signed samples, emits sat(sum>>>SHIFT) one cycle after the last sample.
// Only the dump sample is stalled, and only while an earlier result is still waiting to be taken.
module gbsha_decim #(
  parameter int BW_in      = 8,
  parameter int BW_out     = 8,
  parameter int DECIM_LOG2 = 2,
  parameter int SHIFT      = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic signed [BW_in-1:0]  y_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [BW_out-1:0] y_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sat
);

  localparam int ACC_W = BW_in + DECIM_LOG2;
  // Compare width wide enough for both the shifted sum and the output range.
  localparam int CW    = ((ACC_W > BW_out) ? ACC_W : BW_out) + 1;
  localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;
  localparam logic signed [CW-1:0]  MAX_V    = CW'((1 <<< (BW_out - 1)) - 1);
  localparam logic signed [CW-1:0]  MIN_V    = ~MAX_V;

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DECIM_LOG2-1:0]    cnt_q, cnt_d;
  logic signed [BW_out-1:0] y_out_q, y_out_d;
  logic                     out_valid_q, out_valid_d;
  logic                     sat_q, sat_d;

  logic signed [ACC_W-1:0]  y_ext;
  logic signed [ACC_W-1:0]  sum_w;
  logic signed [ACC_W-1:0]  sum_sh;
  logic signed [CW-1:0]     sh_w;
  logic signed [BW_out-1:0] clamp_val;
  logic                     clamp_hit;
  logic                     last;
  logic                     accept;
  logic                     dump;

  assign y_ext  = {{DECIM_LOG2{y_in[BW_in-1]}}, y_in};
  assign sum_w  = acc_q + y_ext;
  assign sum_sh = sum_w >>> SHIFT;
  assign sh_w   = {{(CW-ACC_W){sum_sh[ACC_W-1]}}, sum_sh};

  assign last     = (cnt_q == CNT_LAST);
  assign in_ready = !(last && out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;
  assign dump     = accept && last;

  always_comb begin
    clamp_val = sh_w[BW_out-1:0];
    clamp_hit = 1'b0;
    if (sh_w > MAX_V) begin
      clamp_val = MAX_V[BW_out-1:0];
      clamp_hit = 1'b1;
    end else if (sh_w < MIN_V) begin
      clamp_val = MIN_V[BW_out-1:0];
      clamp_hit = 1'b1;
    end
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    y_out_d     = y_out_q;
    out_valid_d = out_valid_q;
    sat_d       = sat_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      cnt_d = cnt_q + 1'b1;
      acc_d = sum_w;
    end
    // A dump overrides the consume above, so back-to-back results leave no bubble.
    if (dump) begin
      acc_d       = '0;
      y_out_d     = clamp_val;
      out_valid_d = 1'b1;
      sat_d       = sat_q | clamp_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      y_out_q     <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      y_out_q     <= y_out_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
    end
  end

  assign y_out     = y_out_q;
  assign out_valid = out_valid_q;
  assign sat       = sat_q;

endmodule
